// File: rtl/perip_seg_scan_pkg.sv
// Shared constants for the 4-digit 7-segment scanner: off patterns, digit count,
// hex-to-segment table (active-high g..a) and the digit strobe helper.
package perip_seg_scan_pkg;

  localparam int unsigned DIGITS = 4;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef logic [1:0] digit_idx_t;

  // Entry i is the active-high g..a pattern for hex value i
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [3:0] an_strobe(input digit_idx_t idx);
    logic [3:0] an_v;
    case (idx)
      2'd0:    an_v = 4'b1110;
      2'd1:    an_v = 4'b1101;
      2'd2:    an_v = 4'b1011;
      2'd3:    an_v = 4'b0111;
      default: an_v = AN_OFF;
    endcase
    return an_v;
  endfunction

endpackage

// File: rtl/perip_seg_scan_seg_hex_decode.sv
// Combinational hex digit to active-high g..a segment pattern.
module seg_hex_decode
  import perip_seg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] gfedcba
);

  // Table lookup of the segment pattern
  always_comb begin
    gfedcba = HEX_SEG[hex];
  end

endmodule

// File: rtl/perip_seg_scan.sv
// Latches two display bytes as four hex digits and scans them onto a shared
// common-anode segment bus. Optional leading-zero blanking: define SEG_LZB_EN.
module perip_seg_scan
  import perip_seg_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [7:0]  val_hi,
  input  logic [7:0]  val_lo,
  input  logic [3:0]  dp_in,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        slot_tick
);

  // One extra bit so a blank start of SCAN_DIV (no blanking) is representable
  localparam int PW = $clog2(SCAN_DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_START = PW'(SCAN_DIV - BLANK_CYC);

  logic [15:0]       val_r;
  logic [DIGITS-1:0] dp_r;
  logic [PW-1:0]     presc_r;
  digit_idx_t        idx_r;
  logic [7:0]        seg_r;
  logic [3:0]        an_r;
  logic              slot_tick_r;

  logic              wrap_s;
  logic              slot_blank_s;
  logic [3:0]        digit_s;
  logic              dp_s;
  logic [6:0]        dec_s;
  logic              lz_blank_s;

  assign wrap_s       = (presc_r == PRESC_LAST);
  assign slot_blank_s = (presc_r >= BLANK_START);

  // Shadow registers for the displayed value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_r <= 16'h0000;
      dp_r  <= 4'h0;
    end else if (ena) begin
      val_r <= {val_hi, val_lo};
      dp_r  <= dp_in;
    end else begin
      val_r <= val_r;
      dp_r  <= dp_r;
    end
  end

  // Slot prescaler and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
      idx_r   <= 2'd0;
    end else if (wrap_s) begin
      presc_r <= '0;
      idx_r   <= idx_r + 2'd1;
    end else begin
      presc_r <= presc_r + PW'(1);
      idx_r   <= idx_r;
    end
  end

  // Select the digit and decimal point of the active slot
  always_comb begin
    digit_s = 4'h0;
    dp_s    = 1'b0;
    case (idx_r)
      2'd0: begin digit_s = val_r[3:0];   dp_s = dp_r[0]; end
      2'd1: begin digit_s = val_r[7:4];   dp_s = dp_r[1]; end
      2'd2: begin digit_s = val_r[11:8];  dp_s = dp_r[2]; end
      2'd3: begin digit_s = val_r[15:12]; dp_s = dp_r[3]; end
      default: begin digit_s = 4'h0; dp_s = 1'b0; end
    endcase
  end

  seg_hex_decode u_dec (
    .hex     (digit_s),
    .gfedcba (dec_s)
  );

`ifdef SEG_LZB_EN
  // A digit is a leading zero when it and everything above it is zero with no dp
  always_comb begin
    lz_blank_s = 1'b0;
    case (idx_r)
      2'd0: lz_blank_s = 1'b0;
      2'd1: lz_blank_s = (val_r[15:4]  == 12'h000) && (dp_r[3:1] == 3'b000);
      2'd2: lz_blank_s = (val_r[15:8]  == 8'h00)   && (dp_r[3:2] == 2'b00);
      2'd3: lz_blank_s = (val_r[15:12] == 4'h0)    && (dp_r[3]   == 1'b0);
      default: lz_blank_s = 1'b0;
    endcase
  end
`else
  // Every digit is always shown
  always_comb begin
    lz_blank_s = 1'b0;
  end
`endif

  // Registered pin drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r       <= SEG_OFF;
      an_r        <= AN_OFF;
      slot_tick_r <= 1'b0;
    end else begin
      slot_tick_r <= wrap_s;
      if (slot_blank_s) begin
        seg_r <= SEG_OFF;
        an_r  <= AN_OFF;
      end else if (lz_blank_s) begin
        seg_r <= SEG_OFF;
        an_r  <= an_strobe(idx_r);
      end else begin
        seg_r <= {~dp_s, ~dec_s};
        an_r  <= an_strobe(idx_r);
      end
    end
  end

  assign seg       = seg_r;
  assign an        = an_r;
  assign slot_tick = slot_tick_r;

endmodule
